// File: rtl/rc4_pkg.sv
// Shared types and default widths for the RC4 key-scheduling engine.
package rc4_pkg;

  localparam int RC4_DATA_W = 8;
  localparam int RC4_ADDR_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    FILL,
    RD_I,
    WAIT_I,
    RD_J,
    WAIT_J,
    WR_I,
    WR_J,
    FINISH
  } rc4_state_t;

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Request/status and S-box RAM port bundle for rc4_ksa_engine, plus FSM debug taps.
interface rc4_ksa_engine_if
  import rc4_pkg::*;
#(
  parameter int DATA_W        = RC4_DATA_W,
  parameter int ADDR_W        = RC4_ADDR_W,
  parameter int MAX_KEY_BYTES = 3
);

  localparam int KLEN_W = $clog2(MAX_KEY_BYTES + 1);

  // start is a single-cycle request honoured only while the engine is idle;
  // key/key_len are sampled with it. busy covers the run, done pulses once at
  // the end. There is no backpressure: the RAM answers RAM_RD_LAT cycles after
  // the address is presented and accepts a write in the ram_we cycle.
  logic                            start;
  logic [DATA_W*MAX_KEY_BYTES-1:0] key;
  logic [KLEN_W-1:0]               key_len;
  logic [DATA_W-1:0]               ram_rdata;
  logic [ADDR_W-1:0]               ram_addr;
  logic [DATA_W-1:0]               ram_wdata;
  logic                            ram_we;
  logic                            busy;
  logic                            done;
  rc4_state_t                      dbg_state;
  logic [ADDR_W-1:0]               dbg_i;

  modport master (
    output start, key, key_len, ram_rdata,
    input  ram_addr, ram_wdata, ram_we, busy, done, dbg_state, dbg_i
  );

  modport slave (
    input  start, key, key_len, ram_rdata,
    output ram_addr, ram_wdata, ram_we, busy, done, dbg_state, dbg_i
  );

endinterface

// File: rtl/rc4_key_sel.sv
// Latched key, wrapping key-byte index k and the currently selected key byte.
module rc4_key_sel #(
  parameter int DATA_W        = 8,
  parameter int MAX_KEY_BYTES = 3,
  parameter int KLEN_W        = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_load,
  input  logic [DATA_W*MAX_KEY_BYTES-1:0] i_key,
  input  logic [KLEN_W-1:0]               i_key_len,
  input  logic                            i_advance,
  output logic [DATA_W-1:0]               o_key_byte
);

  logic [DATA_W*MAX_KEY_BYTES-1:0] r_key;
  logic [KLEN_W-1:0]               r_len;
  logic [KLEN_W-1:0]               r_k;
  logic [DATA_W-1:0]               w_key_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key <= '0;
      r_len <= '0;
      r_k   <= '0;
    end else if (i_load) begin
      r_key <= i_key;
      // Zero or oversize lengths fall back to the full key width.
      if (i_key_len == '0 || i_key_len > KLEN_W'(MAX_KEY_BYTES))
        r_len <= KLEN_W'(MAX_KEY_BYTES);
      else
        r_len <= i_key_len;
      r_k <= '0;
    end else if (i_advance) begin
      if (r_k == r_len - KLEN_W'(1))
        r_k <= '0;
      else
        r_k <= r_k + KLEN_W'(1);
    end
  end

  // Byte 0 sits in the most significant lane of the key word.
  always_comb begin
    w_key_byte = '0;
    for (int b = 0; b < MAX_KEY_BYTES; b++) begin
      if (r_k == KLEN_W'(b))
        w_key_byte = r_key[DATA_W*(MAX_KEY_BYTES-1-b) +: DATA_W];
    end
  end

  assign o_key_byte = w_key_byte;

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving an external S-box RAM with configurable read latency.
// Define RC4_KSA_INIT_EN to add the identity FILL pass before shuffling.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int DATA_W        = RC4_DATA_W,
  parameter int ADDR_W        = RC4_ADDR_W,
  parameter int MAX_KEY_BYTES = 3,
  parameter int RAM_RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  rc4_ksa_engine_if.slave    bus
);

  localparam int                KLEN_W    = $clog2(MAX_KEY_BYTES + 1);
  localparam int                WAIT_W    = 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [WAIT_W-1:0] WAIT_END  = WAIT_W'(RAM_RD_LAT - 1);

  rc4_state_t        r_state;
  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;
  logic [DATA_W-1:0] r_si;
  logic [WAIT_W-1:0] r_wait;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_we;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_advance;
  logic [DATA_W-1:0] w_key_byte;
  logic [ADDR_W-1:0] w_j_next;

  assign w_load    = (r_state == IDLE) && bus.start;
  assign w_advance = (r_state == WR_J);
  assign w_j_next  = r_j + ADDR_W'(bus.ram_rdata) + ADDR_W'(w_key_byte);

  rc4_key_sel #(
    .DATA_W        (DATA_W),
    .MAX_KEY_BYTES (MAX_KEY_BYTES),
    .KLEN_W        (KLEN_W)
  ) u_key_sel (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_key      (bus.key),
    .i_key_len  (bus.key_len),
    .i_advance  (w_advance),
    .o_key_byte (w_key_byte)
  );

  // RAM controls are registered: each transition sets them up for the state being entered.
  // s[j] is carried in r_ram_wdata from its capture until the WR_I write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_si        <= '0;
      r_wait      <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ram_addr <= '0;
          if (bus.start) begin
            r_i    <= '0;
            r_j    <= '0;
            r_busy <= 1'b1;
`ifdef RC4_KSA_INIT_EN
            r_state     <= FILL;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b1;
`else
            r_state <= RD_I;
`endif
          end
        end
`ifdef RC4_KSA_INIT_EN
        FILL: begin
          if (r_i == LAST_ADDR) begin
            r_i        <= '0;
            r_ram_addr <= '0;
            r_state    <= RD_I;
          end else begin
            r_i         <= r_i + ADDR_W'(1);
            r_ram_addr  <= r_i + ADDR_W'(1);
            r_ram_wdata <= DATA_W'(r_i + ADDR_W'(1));
            r_ram_we    <= 1'b1;
          end
        end
`endif
        RD_I: begin
          r_wait  <= '0;
          r_state <= WAIT_I;
        end
        WAIT_I: begin
          if (r_wait == WAIT_END) begin
            r_si       <= bus.ram_rdata;
            r_j        <= w_j_next;
            r_ram_addr <= w_j_next;
            r_state    <= RD_J;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        RD_J: begin
          r_wait  <= '0;
          r_state <= WAIT_J;
        end
        WAIT_J: begin
          if (r_wait == WAIT_END) begin
            r_ram_addr  <= r_i;
            r_ram_wdata <= bus.ram_rdata;
            r_ram_we    <= 1'b1;
            r_state     <= WR_I;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        WR_I: begin
          r_ram_addr  <= r_j;
          r_ram_wdata <= r_si;
          r_ram_we    <= 1'b1;
          r_state     <= WR_J;
        end
        WR_J: begin
          if (r_i == LAST_ADDR) begin
            r_ram_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= FINISH;
          end else begin
            r_i        <= r_i + ADDR_W'(1);
            r_ram_addr <= r_i + ADDR_W'(1);
            r_state    <= RD_I;
          end
        end
        FINISH: begin
          r_ram_addr <= '0;
          r_state    <= IDLE;
        end
        default: begin
          r_ram_addr <= '0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_we    = r_ram_we;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;
  assign bus.dbg_i     = r_i;

endmodule

// File: doc/rc4_ksa_engine.md
RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

Interface
REQ-001 Parameter DATA_W, default 8, S-box byte width and key byte width.
REQ-002 Parameter ADDR_W, default 8, S-box address width; S-box depth is 2^ADDR_W.
REQ-003 Parameter MAX_KEY_BYTES, default 3, maximum key length in bytes.
REQ-004 Parameter RAM_RD_LAT, default 1, range 1..4, cycles from registered address to valid ram_rdata.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle request; sampled only in IDLE.
REQ-008 key  in  DATA_W*MAX_KEY_BYTES  key; byte 0 in the most significant DATA_W bits.
REQ-009 key_len  in  $clog2(MAX_KEY_BYTES+1)  active key bytes; sampled with start.
REQ-010 ram_rdata  in  DATA_W  S-box read data.
REQ-011 ram_addr  out  ADDR_W  registered S-box address.
REQ-012 ram_wdata  out  DATA_W  registered S-box write data.
REQ-013 ram_we  out  1  registered write enable.
REQ-014 busy  out  1  high from the cycle after an accepted start until done.
REQ-015 done  out  1  one-cycle pulse on completion.

Function
REQ-016 The FSM SHALL use states IDLE, FILL, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J and FINISH.
REQ-017 IDLE SHALL go to FILL (macro defined) or RD_I (macro undefined) on start; start is ignored in every other state.
REQ-018 Once start is accepted, key and key_len SHALL be latched, so later input changes do not affect the run.
REQ-019 key_len 0 or greater than MAX_KEY_BYTES SHALL be treated as MAX_KEY_BYTES.
REQ-020 RD_I SHALL drive ram_addr=i and ram_we=0; WAIT_I SHALL last RAM_RD_LAT cycles and then capture si=ram_rdata.
REQ-021 On the si capture, the block SHALL compute j=(j+si+key_byte[k]) mod 2^ADDR_W; the sum is truncated, not saturated.
REQ-022 RD_J SHALL drive ram_addr=j; WAIT_J SHALL last RAM_RD_LAT cycles and then capture sj.
REQ-023 WR_I SHALL write s[i]=sj with one ram_we cycle; WR_J SHALL write s[j]=si with one ram_we cycle.
REQ-024 One iteration SHALL take exactly 4+2*RAM_RD_LAT cycles.
REQ-025 The key index k SHALL be a wrapping counter: reset to 0 at start, incremented per iteration, returned to 0 after key_len-1; no modulo divider.
REQ-026 When i==j, both writes SHALL target the same address, leaving s[i] unchanged.
REQ-027 After the WR_J with i=2^ADDR_W-1, the FSM SHALL enter FINISH for one cycle (done=1, busy=0) and then IDLE; i does not wrap into a second pass.
REQ-028 In IDLE and FINISH, ram_we SHALL be 0 and ram_addr SHALL be 0.
REQ-029 A start in the FINISH cycle SHALL be ignored.

Reset
REQ-030 On reset: state=IDLE; i, j, k, si, sj=0; ram_addr=0; ram_wdata=0; ram_we=0; busy=0; done=0.
REQ-031 Reset asserted mid-run SHALL abort at the next edge with no further writes and no done pulse.

Configuration
REQ-032 Macro RC4_KSA_INIT_EN SHALL control the FILL phase.
REQ-033 With RC4_KSA_INIT_EN defined, FILL SHALL write s[a]=a for a=0..2^ADDR_W-1, one write per cycle, before RD_I with i=0.
REQ-034 Without RC4_KSA_INIT_EN, FILL SHALL not exist; shuffling operates on the existing RAM contents.
REQ-035 Total latency from start to done SHALL be 2^ADDR_W*(4+2*RAM_RD_LAT)+1 cycles, plus 2^ADDR_W cycles when the macro is defined.

Structure
REQ-036 Package rc4_pkg SHALL hold the state enum typedef and the constants for the default DATA_W and ADDR_W.
REQ-037 Sub-module rc4_key_sel SHALL hold the latched key, the k counter and the selected key byte output.

Verification
REQ-038 Macro defined, RAM_RD_LAT=1, key=0x000249, key_len=3: the final 256-byte S-box SHALL match a software KSA model, and done SHALL rise exactly 256+256*6+1 cycles after start.
REQ-039 RAM_RD_LAT=3, same key: the S-box SHALL be identical to REQ-038, and done SHALL occur after 256+256*10+1 cycles.
REQ-040 key_len=0 with key=0x010203: the result SHALL equal the key_len=3 result; key_len=1 with key=0x01xxxx SHALL equal the KSA result for the single-byte key 0x01.
REQ-041 A start pulse every cycle while busy: exactly one run SHALL occur and exactly one done pulse SHALL be produced.
REQ-042 Reset asserted at iteration i=100 while in WR_I: ram_we SHALL be 0 the next cycle, busy SHALL be 0, no done pulse SHALL occur, and a new start SHALL give a correct full result.
REQ-043 Macro undefined, RAM preloaded with identity contents, key=0x000000: ram_we SHALL pulse twice per iteration, the first write SHALL be at cycle 3+2*RAM_RD_LAT after start, and the result SHALL match the model.
